// File: rtl/mips_mc_controller_v2.sv
// mips_mc_controller_v2: multi-cycle control unit for the 32-bit MIPS datapath.
// Memory phases (instruction fetch, load, store) end either after a fixed
// wait count or on a mem_ready handshake. Illegal opcodes park the unit in a
// trap state until reset. A counter tracks retired instructions.
module mips_mc_controller_v2 #(
    parameter int MEM_LATENCY = 1,
    parameter bit USE_READY   = 1'b0,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5:0]           IR31_26,
    input  logic [5:0]           IR5_0,
    input  logic                 mem_ready,
    output logic                 PCWriteCond,
    output logic                 PCWrite,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemToReg,
    output logic                 IRWrite,
    output logic                 JumpAndLink,
    output logic                 IsSigned,
    output logic                 ALUSrcA,
    output logic                 RegWrite,
    output logic                 RegDst,
    output logic [1:0]           PCSource,
    output logic [1:0]           ALUSrcB,
    output logic [5:0]           ALUOp,
    output logic                 mem_req,
    output logic                 trap,
    output logic [CNT_WIDTH-1:0] retired
);

    typedef enum logic [4:0] {
        S_FETCH, S_DECODE, S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB,
        S_ADDR_L, S_ADDR_S, S_LOAD_MEM, S_LOAD_WB, S_STORE_MEM,
        S_BR_TGT, S_BR_CMP, S_JR, S_J, S_JAL, S_TRAP
    } state_t;

    localparam logic [5:0] ALU_ADD  = 6'b001001;
    localparam logic [5:0] ALU_PASS = 6'b111110;
    localparam logic [5:0] ALU_NONE = 6'b111111;

    state_t     state, state_next;
    logic [3:0] wcnt;
    logic       started;    // low from reset until the first edge after release
    logic       mem_phase;
    logic       done;
    logic       fetch_done;

    assign mem_phase  = (state == S_FETCH) || (state == S_LOAD_MEM) || (state == S_STORE_MEM);
    assign done       = USE_READY ? mem_ready : (wcnt == 4'(MEM_LATENCY));
    // No fetch strobes may fire while reset is held or before the first edge.
    assign fetch_done = started && done;

    // Map an opcode/funct pair to the first post-decode state.
    function automatic state_t decode(input logic [5:0] op, input logic [5:0] fn);
        state_t s;
        if (op == 6'b000000) begin
            if (fn == 6'b001000)                         s = S_JR;
            else if (fn == 6'b010000 || fn == 6'b010010) s = S_R_WB;
            else                                         s = S_R_EXEC;
        end else begin
            case (op)
                6'b001001, 6'b010000, 6'b001100, 6'b001101,
                6'b001110, 6'b001010, 6'b001011:            s = S_I_EXEC;
                6'b100011:                                  s = S_ADDR_L;
                6'b101011:                                  s = S_ADDR_S;
                6'b000001, 6'b000100, 6'b000101,
                6'b000110, 6'b000111:                       s = S_BR_TGT;
                6'b000010:                                  s = S_J;
                6'b000011:                                  s = S_JAL;
                default:                                    s = S_TRAP;
            endcase
        end
        return s;
    endfunction

    // Run flag: the first fetch cycle begins at the first edge after reset release.
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) started <= 1'b0;
        else        started <= 1'b1;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       state <= S_FETCH;
        else if (started) state <= state_next;
    end

    // Wait counter: cleared on every state change, counts inside memory phases.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt <= 4'd0;
        end else if (started) begin
            if (state_next != state) wcnt <= 4'd0;
            else if (mem_phase)      wcnt <= wcnt + 4'd1;
        end
    end

    // Retired counter: one instruction completes on each return to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired <= '0;
        else if (started && state != S_FETCH && state_next == S_FETCH)
            retired <= retired + CNT_WIDTH'(1);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:     if (done) state_next = S_DECODE;
            S_DECODE:    state_next = decode(IR31_26, IR5_0);
            S_R_EXEC:    state_next = S_R_WB;
            S_I_EXEC:    state_next = S_I_WB;
            S_ADDR_L:    state_next = S_LOAD_MEM;
            S_ADDR_S:    state_next = S_STORE_MEM;
            S_LOAD_MEM:  if (done) state_next = S_LOAD_WB;
            S_STORE_MEM: if (done) state_next = S_FETCH;
            S_BR_TGT:    state_next = S_BR_CMP;
            S_TRAP:      state_next = S_TRAP;
            default:     state_next = S_FETCH;   // R_WB, I_WB, LOAD_WB, BR_CMP, JR, J, JAL
        endcase
    end

    // Datapath controls decoded from state and IR.
    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        PCWriteCond = 1'b0;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b1;
        MemWrite    = 1'b0;
        MemToReg    = 1'b0;
        IRWrite     = 1'b0;
        JumpAndLink = 1'b0;
        IsSigned    = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        PCSource    = 2'b00;
        ALUSrcB     = 2'b00;
        ALUOp       = ALU_NONE;
        mem_req     = 1'b0;
        trap        = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = started;
                if (fetch_done) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = ALU_ADD;
                end
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = IR31_26;
            end
            S_R_WB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                if (IR5_0 == 6'b010000 || IR5_0 == 6'b010010) ALUOp = 6'b000000;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = IR31_26;
            end
            S_I_WB: RegWrite = 1'b1;
            S_ADDR_L, S_ADDR_S, S_LOAD_MEM, S_LOAD_WB: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = ALU_ADD;
                if (state == S_LOAD_MEM) begin
                    IorD    = 1'b1;
                    mem_req = 1'b1;
                end
                if (state == S_LOAD_WB) begin
                    IorD     = 1'b1;
                    MemToReg = 1'b1;
                    RegWrite = 1'b1;
                end
            end
            S_STORE_MEM: begin
                IorD     = 1'b1;
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                mem_req  = 1'b1;
                MemRead  = 1'b0;
                MemWrite = 1'b1;
            end
            S_BR_TGT: begin
                IsSigned = 1'b1;
                ALUSrcB  = 2'b11;
                ALUOp    = ALU_ADD;
            end
            S_BR_CMP: begin
                ALUSrcA     = 1'b1;
                ALUOp       = IR31_26;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JR: begin
                PCWrite = 1'b1;
                ALUSrcA = 1'b1;
                ALUOp   = ALU_PASS;
            end
            S_J: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_JAL: begin
                PCWrite     = 1'b1;
                PCSource    = 2'b10;
                ALUSrcB     = 2'b01;
                ALUOp       = ALU_PASS;
                JumpAndLink = 1'b1;
            end
            S_TRAP: begin
                MemRead = 1'b0;
                trap    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mips_mc_controller_v2.sv
// Testbench for mips_mc_controller_v2. Three instances:
//   dut0: counter mode, MEM_LATENCY=1 (phase length 2)
//   dut1: handshake mode (phase length chosen by the bench via mem_ready)
//   dut2: counter mode, MEM_LATENCY=3 (phase length 4), 2-bit retired counter
// Each instruction is expanded into its expected per-cycle control vectors
// and compared cycle by cycle.
module tb_mips_mc_controller_v2;

    typedef struct packed {
        logic       pc_write_cond, pc_write, ior_d, mem_read, mem_write, mem_to_reg;
        logic       ir_write, jal, is_signed, alu_src_a, reg_write, reg_dst;
        logic [1:0] pc_source, alu_src_b;
        logic [5:0] alu_op;
        logic       mem_req, trap;
    } ctl_t;

    typedef struct {
        ctl_t c;
        logic rdy;
    } step_t;

    typedef enum {K_R, K_MF, K_JR, K_I, K_LW, K_SW, K_BR, K_J, K_JAL, K_ILL} kind_t;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  op  [3];
    logic [5:0]  fn  [3];
    logic        rdy [3];
    ctl_t        o   [3];
    logic [31:0] ret [3];

    int          n_vec = 0;
    int          n_err = 0;
    int unsigned exp_ret [3];
    step_t       q[$];

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CW = (g == 2) ? 2 : 32;
        logic pcwc, pcw, iord, mr, mw, m2r, irw, jl, iss, asa, rw, rd, mreq, trp;
        logic [1:0]    pcs, asb;
        logic [5:0]    aop;
        logic [CW-1:0] r;

        mips_mc_controller_v2 #(
            .MEM_LATENCY((g == 2) ? 3 : 1),
            .USE_READY  ((g == 1) ? 1'b1 : 1'b0),
            .CNT_WIDTH  (CW)
        ) dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .IR31_26    (op[g]),
            .IR5_0      (fn[g]),
            .mem_ready  (rdy[g]),
            .PCWriteCond(pcwc),
            .PCWrite    (pcw),
            .IorD       (iord),
            .MemRead    (mr),
            .MemWrite   (mw),
            .MemToReg   (m2r),
            .IRWrite    (irw),
            .JumpAndLink(jl),
            .IsSigned   (iss),
            .ALUSrcA    (asa),
            .RegWrite   (rw),
            .RegDst     (rd),
            .PCSource   (pcs),
            .ALUSrcB    (asb),
            .ALUOp      (aop),
            .mem_req    (mreq),
            .trap       (trp),
            .retired    (r)
        );

        assign o[g]   = {pcwc, pcw, iord, mr, mw, m2r, irw, jl, iss, asa, rw, rd,
                         pcs, asb, aop, mreq, trp};
        assign ret[g] = 32'(r);
    end

    // ---------------- reference model ----------------
    function automatic ctl_t dv();
        ctl_t c = '0;
        c.mem_read = 1'b1;
        c.alu_op   = 6'b111111;
        return c;
    endfunction

    function automatic kind_t kind_of(input logic [5:0] opc, input logic [5:0] fnc);
        if (opc == 6'b000000) begin
            if (fnc == 6'b001000) return K_JR;
            if (fnc == 6'b010000 || fnc == 6'b010010) return K_MF;
            return K_R;
        end
        case (opc)
            6'b001001, 6'b010000, 6'b001100, 6'b001101,
            6'b001110, 6'b001010, 6'b001011:             return K_I;
            6'b100011:                                   return K_LW;
            6'b101011:                                   return K_SW;
            6'b000001, 6'b000100, 6'b000101,
            6'b000110, 6'b000111:                        return K_BR;
            6'b000010:                                   return K_J;
            6'b000011:                                   return K_JAL;
            default:                                     return K_ILL;
        endcase
    endfunction

    function automatic logic noise();
        return logic'($urandom_range(0, 1));
    endfunction

    function automatic void push(input ctl_t c, input logic r);
        step_t s;
        s.c   = c;
        s.rdy = r;
        q.push_back(s);
    endfunction

    function automatic logic [31:0] ret_exp(input int idx);
        return (idx == 2) ? (exp_ret[idx] % 4) : exp_ret[idx];
    endfunction

    // Expand one instruction into expected per-cycle controls.
    // lf/lm: fetch and data-memory phase lengths in cycles.
    function automatic void build(input int idx, input logic [5:0] opc, input logic [5:0] fnc,
                                  input int lf, input int lm);
        ctl_t c, a;
        bit   hs = (idx == 1);
        q.delete();
        for (int i = 0; i < lf; i++) begin
            c = dv();
            c.mem_req = 1'b1;
            if (i == lf - 1) begin
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
                c.alu_src_b = 2'b01;
                c.alu_op    = 6'b001001;
            end
            push(c, hs ? logic'(i == lf - 1) : noise());
        end
        push(dv(), noise());
        a = dv();
        a.alu_src_a = 1'b1;
        a.alu_src_b = 2'b10;
        a.alu_op    = 6'b001001;
        case (kind_of(opc, fnc))
            K_R: begin
                c = dv(); c.alu_src_a = 1'b1; c.alu_op = opc; push(c, noise());
                c = dv(); c.reg_dst = 1'b1; c.reg_write = 1'b1; push(c, noise());
            end
            K_MF: begin
                c = dv(); c.reg_dst = 1'b1; c.reg_write = 1'b1; c.alu_op = 6'b000000; push(c, noise());
            end
            K_I: begin
                c = dv(); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = opc; push(c, noise());
                c = dv(); c.reg_write = 1'b1; push(c, noise());
            end
            K_LW: begin
                push(a, noise());
                for (int i = 0; i < lm; i++) begin
                    c = a; c.ior_d = 1'b1; c.mem_req = 1'b1;
                    push(c, hs ? logic'(i == lm - 1) : noise());
                end
                c = a; c.ior_d = 1'b1; c.mem_to_reg = 1'b1; c.reg_write = 1'b1; push(c, noise());
            end
            K_SW: begin
                push(a, noise());
                for (int i = 0; i < lm; i++) begin
                    c = dv(); c.ior_d = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                    c.mem_req = 1'b1; c.mem_read = 1'b0; c.mem_write = 1'b1;
                    push(c, hs ? logic'(i == lm - 1) : noise());
                end
            end
            K_BR: begin
                c = dv(); c.is_signed = 1'b1; c.alu_src_b = 2'b11; c.alu_op = 6'b001001; push(c, noise());
                c = dv(); c.alu_src_a = 1'b1; c.alu_op = opc; c.pc_write_cond = 1'b1;
                c.pc_source = 2'b01; push(c, noise());
            end
            K_JR: begin
                c = dv(); c.pc_write = 1'b1; c.alu_src_a = 1'b1; c.alu_op = 6'b111110; push(c, noise());
            end
            K_J: begin
                c = dv(); c.pc_write = 1'b1; c.pc_source = 2'b10; push(c, noise());
            end
            K_JAL: begin
                c = dv(); c.pc_write = 1'b1; c.pc_source = 2'b10; c.alu_src_b = 2'b01;
                c.alu_op = 6'b111110; c.jal = 1'b1; push(c, noise());
            end
            default: begin
                for (int i = 0; i < 20; i++) begin
                    c = dv(); c.mem_read = 1'b0; c.trap = 1'b1; push(c, noise());
                end
            end
        endcase
    endfunction

    // ---------------- drivers ----------------
    // Play the first n expected steps; entered and left one tick after a rising edge.
    task automatic play(input int idx, input string name, input int n);
        for (int k = 0; k < n; k++) begin
            rdy[idx] = q[k].rdy;
            @(negedge clk);
            n_vec++;
            if (o[idx] !== q[k].c) begin
                n_err++;
                $display("FAIL %s dut%0d cycle %0d: ctl got %h want %h", name, idx, k, o[idx], q[k].c);
            end
            @(posedge clk);
            #1;
        end
        rdy[idx] = 1'b0;
    endtask

    task automatic run_instr(input int idx, input string name, input logic [5:0] opc,
                             input logic [5:0] fnc, input int lf, input int lm);
        op[idx] = opc;
        fn[idx] = fnc;
        n_vec++;
        if (ret[idx] !== ret_exp(idx)) begin
            n_err++;
            $display("FAIL %s dut%0d retired before: got %0d want %0d", name, idx, ret[idx], ret_exp(idx));
        end
        build(idx, opc, fnc, lf, lm);
        play(idx, name, q.size());
        if (kind_of(opc, fnc) != K_ILL) exp_ret[idx]++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (o[i].mem_req !== 1'b0) begin
                n_err++;
                $display("FAIL prestart dut%0d mem_req: got %b want 0", i, o[i].mem_req);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) exp_ret[i] = 0;
    endtask

    task automatic do_reset(input string name);
        ctl_t rv;
        rv = dv();
        for (int i = 0; i < 3; i++) rdy[i] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (o[i] !== rv || ret[i] !== 32'd0) begin
                n_err++;
                $display("FAIL %s dut%0d: ctl %h retired %0d, want ctl %h retired 0",
                         name, i, o[i], ret[i], rv);
            end
        end
        @(posedge clk);
        release_reset();
    endtask

    function automatic logic [5:0] plain_fn();
        logic [5:0] f;
        do f = 6'($urandom); while (f == 6'b001000 || f == 6'b010000 || f == 6'b010010);
        return f;
    endfunction

    function automatic int plen(input int idx);
        return (idx == 1) ? int'($urandom_range(1, 4)) : ((idx == 2) ? 4 : 2);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset("reset");
    endtask

    task automatic test_addiu();
        do_reset("addiu_rst");
        run_instr(0, "addiu", 6'b001001, plain_fn(), 2, 2);
        n_vec++;
        if (ret[0] !== 32'd1) begin
            n_err++;
            $display("FAIL addiu retired: got %0d want 1", ret[0]);
        end
    endtask

    task automatic test_lw_ready();
        do_reset("lw_rst");
        run_instr(1, "lw_ready", 6'b100011, plain_fn(), int'($urandom_range(1, 4)), 4);
        run_instr(1, "lw_ready2", 6'b100011, plain_fn(), 1, 1);
    endtask

    task automatic test_sw_lat3();
        do_reset("sw_rst");
        run_instr(2, "sw_lat3", 6'b101011, plain_fn(), 4, 4);
        run_instr(2, "after_sw", 6'b001101, plain_fn(), 4, 4);
    endtask

    task automatic test_trap();
        do_reset("trap_rst");
        run_instr(0, "pre_trap", 6'b001100, plain_fn(), 2, 2);
        run_instr(0, "trap", 6'b111111, plain_fn(), 2, 2);
        do_reset("trap_exit");
    endtask

    task automatic test_jumps();
        do_reset("jump_rst");
        run_instr(0, "jal", 6'b000011, plain_fn(), 2, 2);
        run_instr(0, "j", 6'b000010, plain_fn(), 2, 2);
        run_instr(0, "jr", 6'b000000, 6'b001000, 2, 2);
        run_instr(0, "mflo", 6'b000000, 6'b010010, 2, 2);
    endtask

    task automatic test_reset_mid_store();
        ctl_t rv;
        rv = dv();
        do_reset("mid_rst");
        run_instr(2, "pre_store", 6'b001001, plain_fn(), 4, 4);
        op[2] = 6'b101011;
        fn[2] = plain_fn();
        build(2, 6'b101011, fn[2], 4, 4);
        play(2, "store_head", 7);         // fetch x4, decode, addr, store cycle 1
        @(negedge clk);
        n_vec++;
        if (o[2].mem_write !== 1'b1) begin
            n_err++;
            $display("FAIL mid_store MemWrite before reset: got %b want 1", o[2].mem_write);
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if (o[2] !== rv || ret[2] !== 32'd0) begin
            n_err++;
            $display("FAIL mid_store after reset: ctl %h retired %0d, want ctl %h retired 0",
                     o[2], ret[2], rv);
        end
        release_reset();
        run_instr(2, "beq", 6'b000100, plain_fn(), 4, 4);
    endtask

    task automatic test_wrap();
        do_reset("wrap_rst");
        for (int i = 0; i < 5; i++) run_instr(2, "wrap", 6'b000010, plain_fn(), 4, 4);
        n_vec++;
        if (ret[2] !== 32'd1) begin
            n_err++;
            $display("FAIL wrap retired: got %0d want 1", ret[2]);
        end
    endtask

    task automatic test_random();
        logic [5:0] legal [16] = '{6'b001001, 6'b010000, 6'b001100, 6'b001101,
                                   6'b001110, 6'b001010, 6'b001011, 6'b100011,
                                   6'b101011, 6'b000001, 6'b000100, 6'b000101,
                                   6'b000110, 6'b000111, 6'b000010, 6'b000011};
        logic [5:0] opc, fnc;
        int         r;
        for (int idx = 0; idx < 3; idx++) begin
            do_reset("rand_rst");
            for (int n = 0; n < 25; n++) begin
                r = int'($urandom_range(0, 19));
                case (r)
                    0:       begin opc = 6'b000000; fnc = plain_fn(); end
                    1:       begin opc = 6'b000000; fnc = 6'b001000; end
                    2:       begin opc = 6'b000000; fnc = 6'b010000; end
                    3:       begin opc = 6'b000000; fnc = 6'b010010; end
                    default: begin opc = legal[r - 4]; fnc = plain_fn(); end
                endcase
                run_instr(idx, "random", opc, fnc, plen(idx), plen(idx));
            end
            n_vec++;
            if (ret[idx] !== ret_exp(idx)) begin
                n_err++;
                $display("FAIL random dut%0d final retired: got %0d want %0d", idx, ret[idx], ret_exp(idx));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            op[i]  = 6'b0;
            fn[i]  = 6'b0;
            rdy[i] = 1'b0;
        end
        #12;
        test_reset();
        test_addiu();
        test_lw_ready();
        test_sw_lat3();
        test_trap();
        test_jumps();
        test_reset_mid_store();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
